// File: rtl/io_device_port.sv
// io_device_port: host-side byte FIFOs bridged to a processor
// through two four-phase handshake links (deliver and capture).
module io_device_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hostWrEn,
  input  logic [WIDTH-1:0] hostWrData,
  output logic             hostFull,
  output logic             hostOvf,
  input  logic             hostRdEn,
  output logic [WIDTH-1:0] hostRdData,
  output logic             hostEmpty,
  output logic [WIDTH-1:0] procIn,
  output logic             inDataReady,
  input  logic             inACK,
  input  logic [WIDTH-1:0] procOut,
  input  logic             outDataReady,
  output logic             outACK
);

  localparam logic [AW:0]   LP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LP_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] LP_PINC = AW'(1);

  typedef enum logic [1:0] {
    D_IDLE,
    D_OFFER,
    D_RELEASE
  } d_state_t;

  typedef enum logic {
    C_IDLE,
    C_ACK
  } c_state_t;

  logic [WIDTH-1:0] r_tx_mem [DEPTH];
  logic [AW-1:0]    r_tx_wp;
  logic [AW-1:0]    r_tx_rp;
  logic [AW:0]      r_tx_cnt;
  logic [WIDTH-1:0] r_rx_mem [DEPTH];
  logic [AW-1:0]    r_rx_wp;
  logic [AW-1:0]    r_rx_rp;
  logic [AW:0]      r_rx_cnt;
  logic             r_ovf;

  d_state_t         r_d_st;
  d_state_t         w_d_nxt;
  logic             r_idr;
  logic             w_idr_nxt;
  logic [WIDTH-1:0] r_pin;
  logic [WIDTH-1:0] w_pin_nxt;
  logic             w_tx_pop;
  logic             w_tx_push;

  c_state_t         r_c_st;
  c_state_t         w_c_nxt;
  logic             r_ack;
  logic             w_ack_nxt;
  logic             w_rx_push;
  logic             w_rx_pop;

  // Full/empty are judged on the pre-update count, so a same-cycle
  // pop never makes room for a push and vice versa.
  assign w_tx_push = hostWrEn && (r_tx_cnt != LP_FULL);
  assign w_rx_pop  = hostRdEn && (r_rx_cnt != '0);

  assign hostFull    = (r_tx_cnt == LP_FULL);
  assign hostEmpty   = (r_rx_cnt == '0);
  assign hostOvf     = r_ovf;
  assign hostRdData  = hostEmpty ? '0 : r_rx_mem[r_rx_rp];
  assign procIn      = r_pin;
  assign inDataReady = r_idr;
  assign outACK      = r_ack;

  // TX storage: host writes land here, no reset needed on data.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= hostWrData;
  end

  // TX pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + LP_PINC;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + LP_PINC;
      if (w_tx_push && !w_tx_pop)
        r_tx_cnt <= r_tx_cnt + LP_ONE;
      else if (!w_tx_push && w_tx_pop)
        r_tx_cnt <= r_tx_cnt - LP_ONE;
      if (hostWrEn && !w_tx_push) r_ovf <= 1'b1;
    end
  end

  // RX storage: bytes captured from the processor.
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp] <= procOut;
  end

  // RX pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + LP_PINC;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + LP_PINC;
      if (w_rx_push && !w_rx_pop)
        r_rx_cnt <= r_rx_cnt + LP_ONE;
      else if (!w_rx_push && w_rx_pop)
        r_rx_cnt <= r_rx_cnt - LP_ONE;
    end
  end

  // Deliver link state and its registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d_st <= D_IDLE;
      r_idr  <= 1'b0;
      r_pin  <= '0;
    end else begin
      r_d_st <= w_d_nxt;
      r_idr  <= w_idr_nxt;
      r_pin  <= w_pin_nxt;
    end
  end

  // Deliver link: offer TX head, pop on ack, wait for ack release.
  always_comb begin
    w_d_nxt   = r_d_st;
    w_idr_nxt = r_idr;
    w_pin_nxt = r_pin;
    w_tx_pop  = 1'b0;
    unique case (r_d_st)
      D_IDLE: begin
        if (r_tx_cnt != '0) begin
          w_pin_nxt = r_tx_mem[r_tx_rp];
          w_idr_nxt = 1'b1;
          w_d_nxt   = D_OFFER;
        end
      end
      D_OFFER: begin
        if (inACK) begin
          w_tx_pop  = 1'b1;
          w_idr_nxt = 1'b0;
          w_d_nxt   = D_RELEASE;
        end
      end
      D_RELEASE: begin
        if (!inACK) w_d_nxt = D_IDLE;
      end
      default: begin
        w_d_nxt   = D_IDLE;
        w_idr_nxt = 1'b0;
      end
    endcase
  end

  // Capture link state and its registered acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_c_st <= C_IDLE;
      r_ack  <= 1'b0;
    end else begin
      r_c_st <= w_c_nxt;
      r_ack  <= w_ack_nxt;
    end
  end

  // Capture link: one RX write per handshake, stall while RX full.
  always_comb begin
    w_c_nxt   = r_c_st;
    w_ack_nxt = r_ack;
    w_rx_push = 1'b0;
    unique case (r_c_st)
      C_IDLE: begin
        if (outDataReady && (r_rx_cnt != LP_FULL)) begin
          w_rx_push = 1'b1;
          w_ack_nxt = 1'b1;
          w_c_nxt   = C_ACK;
        end
      end
      C_ACK: begin
        if (!outDataReady) begin
          w_ack_nxt = 1'b0;
          w_c_nxt   = C_IDLE;
        end
      end
      default: begin
        w_c_nxt   = C_IDLE;
        w_ack_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_io_device_port.sv
// tb_io_device_port: randomized host/processor traffic checked
// against a queue-based scoreboard of the port's behaviour.
module tb_io_device_port;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         hostWrEn = 1'b0;
  logic [W-1:0] hostWrData = '0;
  logic         hostFull;
  logic         hostOvf;
  logic         hostRdEn = 1'b0;
  logic [W-1:0] hostRdData;
  logic         hostEmpty;
  logic [W-1:0] procIn;
  logic         inDataReady;
  logic         inACK = 1'b0;
  logic [W-1:0] procOut = '0;
  logic         outDataReady = 1'b0;
  logic         outACK;

  io_device_port #(.WIDTH(W), .DEPTH(D), .AW(2)) dut (
    .clk(clk),
    .reset(reset),
    .hostWrEn(hostWrEn),
    .hostWrData(hostWrData),
    .hostFull(hostFull),
    .hostOvf(hostOvf),
    .hostRdEn(hostRdEn),
    .hostRdData(hostRdData),
    .hostEmpty(hostEmpty),
    .procIn(procIn),
    .inDataReady(inDataReady),
    .inACK(inACK),
    .procOut(procOut),
    .outDataReady(outDataReady),
    .outACK(outACK)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: bytes the processor should be offered, in order,
  // and bytes the host should read back, in order.
  logic [W-1:0] q_tx[$];
  logic [W-1:0] q_rx[$];
  int  tx_occ = 0;
  int  rx_occ = 0;
  bit  exp_ovf = 1'b0;
  // deliver link phase: 0 quiet, 1 byte offered, 2 awaiting ack low
  int  link_in = 0;
  // capture link: acknowledge currently expected high
  bit  link_out_ack = 1'b0;
  bit  rd_fire = 1'b0;
  logic [W-1:0] mon_last = '0;
  bit  mon_prev = 1'b0;
  int  rst_hits = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q_tx.delete();
    q_rx.delete();
    tx_occ = 0;
    rx_occ = 0;
    exp_ovf = 1'b0;
    link_in = 0;
    link_out_ack = 1'b0;
    rd_fire = 1'b0;
    mon_last = '0;
    mon_prev = 1'b0;
  endtask

  // Apply the inputs now being driven to the scoreboard as of the
  // coming rising edge. Full/empty use occupancy before that edge.
  task automatic predict();
    int t0;
    int r0;
    bit pop;
    bit push;
    bit cap;
    t0 = tx_occ;
    r0 = rx_occ;
    pop  = (link_in == 1) && inACK;
    push = hostWrEn && (t0 < D);
    if (hostWrEn && !push) exp_ovf = 1'b1;
    if (push) q_tx.push_back(hostWrData);
    tx_occ = t0 + int'(push) - int'(pop);
    if (link_in == 0) begin
      if (t0 > 0) link_in = 1;
    end else if (link_in == 1) begin
      if (inACK) link_in = 2;
    end else if (!inACK) begin
      link_in = 0;
    end
    cap = !link_out_ack && outDataReady && (r0 < D);
    rd_fire = hostRdEn && (r0 > 0);
    if (cap) q_rx.push_back(procOut);
    if (link_out_ack && !outDataReady) link_out_ack = 1'b0;
    else if (cap) link_out_ack = 1'b1;
    rx_occ = r0 + int'(cap) - int'(rd_fire);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_inDataReady"}, 32'(inDataReady), 32'(0));
    chk({tag, "_outACK"}, 32'(outACK), 32'(0));
    chk({tag, "_hostEmpty"}, 32'(hostEmpty), 32'(1));
    chk({tag, "_hostFull"}, 32'(hostFull), 32'(0));
    chk({tag, "_hostOvf"}, 32'(hostOvf), 32'(0));
    chk({tag, "_procIn"}, 32'(procIn), 32'(0));
    chk({tag, "_hostRdData"}, 32'(hostRdData), 32'(0));
  endtask

  // Monitor: each new offer must carry the next accepted host byte,
  // and procIn must otherwise hold its last offered value.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (inDataReady && !mon_prev) begin
        if (q_tx.size() == 0)
          chk("offer_without_byte", 32'(1), 32'(0));
        else
          mon_last = q_tx.pop_front();
      end
      chk("procIn", 32'(procIn), 32'(mon_last));
      mon_prev = inDataReady;
    end
  end

  // Monitor: every host read must return the oldest captured byte.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rd_fire) begin
        if (q_rx.size() == 0)
          chk("read_without_byte", 32'(1), 32'(0));
        else
          chk("hostRdData", 32'(hostRdData), 32'(q_rx.pop_front()));
      end
    end
  end

  int wr_pct [4] = '{60, 30, 70, 20};
  int rd_pct [4] = '{0, 40, 70, 20};
  int ack_pct[4] = '{0, 60, 90, 10};
  int snd_pct[4] = '{80, 60, 90, 40};
  int rel_pct[4] = '{50, 20, 90, 50};
  bit rst_want[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    model_clear();
    #3;
    chk_reset_outs("por");
    @(negedge clk);
    reset = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int s = 0; s < 4; s++) begin
        bit want;
        want = rst_want[s];
        for (int c = 0; c < 450; c++) begin
          @(negedge clk);
          chk("inDataReady", 32'(inDataReady), 32'(link_in == 1));
          chk("outACK", 32'(outACK), 32'(link_out_ack));
          chk("hostFull", 32'(hostFull), 32'(tx_occ == D));
          chk("hostEmpty", 32'(hostEmpty), 32'(rx_occ == 0));
          chk("hostOvf", 32'(hostOvf), 32'(exp_ovf));
          if (want && (link_in == 1) && link_out_ack) begin
            want = 1'b0;
            rst_hits++;
            #1 reset = 1'b1;
            #1;
            chk_reset_outs("midrst");
            hostWrEn = 1'b0;
            hostRdEn = 1'b0;
            inACK = 1'b0;
            outDataReady = 1'b0;
            model_clear();
            reset = 1'b0;
          end else begin
            hostWrEn = ($urandom_range(99) < wr_pct[s]);
            hostWrData = 8'($urandom_range(255));
            hostRdEn = ($urandom_range(99) < rd_pct[s]);
            if (link_in == 1)
              inACK = ($urandom_range(99) < ack_pct[s]);
            else if (link_in == 2) begin
              if ($urandom_range(99) < rel_pct[s]) inACK = 1'b0;
            end else
              inACK = 1'b0;
            if (!link_out_ack) begin
              if (!outDataReady &&
                  ($urandom_range(99) < snd_pct[s])) begin
                outDataReady = 1'b1;
                procOut = 8'($urandom_range(255));
              end
            end else if ($urandom_range(99) < 50) begin
              outDataReady = 1'b0;
            end
            predict();
          end
        end
      end
    end
    @(negedge clk);
    chk("mid_reset_hits", 32'(rst_hits), 32'(4));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
